// File: rtl/scr1_dmem_responder.sv
// rtl/scr1_dmem_responder.sv - DMEM responder with local word RAM, wait states and error responses
module scr1_dmem_responder #(
   parameter int MEM_WORDS   = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        dmem_req_ack,
   input  logic        dmem_req,
   input  logic        dmem_cmd,
   input  logic [1:0]  dmem_width,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic [1:0]  dmem_resp
);
   localparam int         ABITS       = $clog2(MEM_WORDS * 4);
   localparam logic [1:0] RESP_NOTRDY = 2'd0;
   localparam logic [1:0] RESP_OK     = 2'd1;
   localparam logic [1:0] RESP_ER     = 2'd2;
   localparam logic [1:0] W_BYTE      = 2'd0;
   localparam logic [1:0] W_HWORD     = 2'd1;
   localparam logic [1:0] W_WORD      = 2'd2;
   localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state;
   logic [3:0]        wait_cnt;
   logic              resp_err;
   logic [31:0]       resp_data;
   logic [31:0]       mem [MEM_WORDS];
   logic [ABITS-3:0]  word_idx;
   logic              accept;
   logic              req_err;
   logic [3:0]        lane_en;
   logic              unused_addr_bits;

   // Address decode happens upstream; offset wraps within the local RAM.
   assign word_idx         = dmem_addr[ABITS-1:2];
   assign unused_addr_bits = ^dmem_addr[31:ABITS];

   assign dmem_req_ack = rst_n && (state != S_WAIT);
   assign accept       = dmem_req && dmem_req_ack;

   always_comb begin
      req_err = 1'b0;
      lane_en = 4'b0000;
      case (dmem_width)
         W_BYTE:  lane_en = 4'b0001 << dmem_addr[1:0];
         W_HWORD: begin
            req_err = dmem_addr[0];
            lane_en = dmem_addr[1] ? 4'b1100 : 4'b0011;
         end
         W_WORD: begin
            req_err = (dmem_addr[1:0] != 2'b00);
            lane_en = 4'b1111;
         end
         default: req_err = 1'b1;
      endcase
   end

   // Writes commit at acceptance so any later read, even back-to-back, sees them.
   always_ff @(posedge clk) begin
      if (accept && dmem_cmd && !req_err) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
               mem[word_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         wait_cnt  <= 4'd0;
         resp_err  <= 1'b0;
         resp_data <= 32'd0;
      end else begin
         case (state)
            S_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt <= 4'd1) begin
                  state <= S_RESP;
               end
            end
            default: begin
               if (accept) begin
                  resp_err  <= req_err;
                  resp_data <= (!dmem_cmd && !req_err) ? mem[word_idx] : 32'd0;
                  wait_cnt  <= WAIT_LOAD;
                  state     <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

   // Gating with rst_n drops a pending response the moment reset is applied.
   assign dmem_resp  = (rst_n && state == S_RESP) ? (resp_err ? RESP_ER : RESP_OK) : RESP_NOTRDY;
   assign dmem_rdata = (rst_n && state == S_RESP && !resp_err) ? resp_data : 32'd0;

endmodule

// File: tb/tb_scr1_dmem_responder.sv
// tb/tb_scr1_dmem_responder.sv - self-checking bench for scr1_dmem_responder
module tb_scr1_dmem_responder;
   logic        clk = 1'b0;
   logic        rstn  [3];
   logic        ack   [3];
   logic        req   [3];
   logic        cmd   [3];
   logic [1:0]  width [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];
   logic [1:0]  resp  [3];
   logic [31:0] model [3][1024];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   scr1_dmem_responder #(.MEM_WORDS(1024), .WAIT_STATES(1)) dut_a (
      .clk(clk), .rst_n(rstn[0]), .dmem_req_ack(ack[0]), .dmem_req(req[0]), .dmem_cmd(cmd[0]),
      .dmem_width(width[0]), .dmem_addr(addr[0]), .dmem_wdata(wdata[0]), .dmem_rdata(rdata[0]),
      .dmem_resp(resp[0]));
   scr1_dmem_responder #(.MEM_WORDS(1024), .WAIT_STATES(0)) dut_b (
      .clk(clk), .rst_n(rstn[1]), .dmem_req_ack(ack[1]), .dmem_req(req[1]), .dmem_cmd(cmd[1]),
      .dmem_width(width[1]), .dmem_addr(addr[1]), .dmem_wdata(wdata[1]), .dmem_rdata(rdata[1]),
      .dmem_resp(resp[1]));
   scr1_dmem_responder #(.MEM_WORDS(16), .WAIT_STATES(3)) dut_c (
      .clk(clk), .rst_n(rstn[2]), .dmem_req_ack(ack[2]), .dmem_req(req[2]), .dmem_cmd(cmd[2]),
      .dmem_width(width[2]), .dmem_addr(addr[2]), .dmem_wdata(wdata[2]), .dmem_rdata(rdata[2]),
      .dmem_resp(resp[2]));

   function automatic int mw_of(input int k);
      return (k == 2) ? 16 : 1024;
   endfunction

   function automatic int ws_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: byte-addressed memory viewed as words; expected response from the access rules.
   task automatic model_step(input int k, input logic c, input logic [1:0] w, input logic [31:0] a,
                             input logic [31:0] d, output logic [1:0] er, output logic [31:0] ed);
      int idx;
      int off;
      bit bad;
      idx = int'((a / 4) % 32'(mw_of(k)));
      off = int'(a % 4);
      bad = (w == 3) || (w == 1 && off % 2 == 1) || (w == 2 && off != 0);
      er  = 2'd1;
      ed  = 32'd0;
      if (bad) begin
         er = 2'd2;
      end else if (c) begin
         for (int lane = 0; lane < 4; lane++) begin
            if ((w == 0 && lane == off) || (w == 1 && lane / 2 == off / 2) || w == 2) begin
               model[k][idx][8*lane +: 8] = d[8*lane +: 8];
            end
         end
      end else begin
         ed = model[k][idx];
      end
   endtask

   task automatic drive(input int k, input logic c, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d);
      req[k] = 1'b1; cmd[k] = c; width[k] = w; addr[k] = a; wdata[k] = d;
   endtask

   task automatic scramble(input int k);
      req[k] = 1'b0; cmd[k] = 1'($urandom); width[k] = 2'($urandom);
      addr[k] = $urandom; wdata[k] = $urandom;
   endtask

   task automatic txn(input int k, input logic c, input logic [1:0] w, input logic [31:0] a,
                      input logic [31:0] d, input string tag);
      logic [1:0]  er;
      logic [31:0] ed;
      int          n;
      model_step(k, c, w, a, d, er, ed);
      @(negedge clk);
      drive(k, c, w, a, d);
      n = 0;
      while (ack[k] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ack"}, 32'(ack[k]), 32'd1);
      @(negedge clk);
      scramble(k);
      for (int i = 0; i < ws_of(k); i++) begin
         chk({tag, "_wait_resp"}, 32'(resp[k]), 32'd0);
         chk({tag, "_wait_ack"}, 32'(ack[k]), 32'd0);
         chk({tag, "_wait_rdata"}, rdata[k], 32'd0);
         @(negedge clk);
      end
      chk({tag, "_resp"}, 32'(resp[k]), 32'(er));
      chk({tag, "_rdata"}, rdata[k], ed);
      chk({tag, "_resp_ack"}, 32'(ack[k]), 32'd1);
   endtask

   initial begin
      logic        bc [3];
      logic [31:0] ba [3];
      logic [31:0] bd [3];
      logic [1:0]  ber [3];
      logic [31:0] bed [3];
      logic [1:0]  er;
      logic [31:0] ed;
      int          n;

      for (int k = 0; k < 3; k++) begin
         rstn[k] = 1'b0; req[k] = 1'b0; cmd[k] = 1'b0; width[k] = 2'd0;
         addr[k] = 32'd0; wdata[k] = 32'd0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("reset_ack", 32'(ack[k]), 32'd0);
         chk("reset_resp", 32'(resp[k]), 32'd0);
         chk("reset_rdata", rdata[k], 32'd0);
         rstn[k] = 1'b1;
      end

      // One wait state: basic write/read, lane merge, error cases
      txn(0, 1'b1, 2'd2, 32'h0001_0010, 32'hDEAD_BEEF, "wr_word");
      txn(0, 1'b0, 2'd2, 32'h0001_0010, 32'h0, "rd_word");
      txn(0, 1'b1, 2'd2, 32'h10, 32'h1122_3344, "wr_base");
      txn(0, 1'b1, 2'd0, 32'h13, 32'hAA00_0000, "wr_byte");
      txn(0, 1'b1, 2'd1, 32'h10, 32'h0000_5566, "wr_hword");
      txn(0, 1'b0, 2'd2, 32'h10, 32'h0, "rd_merge");
      chk("merge_value", model[0][4], 32'hAA22_5566);
      txn(0, 1'b0, 2'd1, 32'h11, 32'h0, "rd_hword_mis");
      txn(0, 1'b1, 2'd2, 32'h12, 32'hFFFF_FFFF, "wr_word_mis");
      txn(0, 1'b0, 2'd3, 32'h10, 32'h0, "rd_width3");
      txn(0, 1'b0, 2'd2, 32'h10, 32'h0, "rd_unchanged");

      // Zero wait states, back-to-back requests
      txn(1, 1'b1, 2'd2, 32'h24, 32'hCAFE_0001, "b2b_pre");
      bc = '{1'b1, 1'b0, 1'b0};
      ba = '{32'h20, 32'h20, 32'h24};
      bd = '{32'h1, 32'h0, 32'h0};
      for (int i = 0; i < 3; i++) model_step(1, bc[i], 2'd2, ba[i], bd[i], ber[i], bed[i]);
      @(negedge clk);
      drive(1, bc[0], 2'd2, ba[0], bd[0]);
      for (int i = 0; i < 3; i++) begin
         chk("b2b_ack", 32'(ack[1]), 32'd1);
         @(negedge clk);
         chk("b2b_resp", 32'(resp[1]), 32'(ber[i]));
         chk("b2b_rdata", rdata[1], bed[i]);
         if (i < 2) drive(1, bc[i+1], 2'd2, ba[i+1], bd[i+1]);
         else scramble(1);
      end
      chk("b2b_first_read", bed[1], 32'h1);

      // Three wait states: reset during WAIT drops the response, write persists
      model_step(2, 1'b1, 2'd2, 32'h30, 32'h55, er, ed);
      @(negedge clk);
      drive(2, 1'b1, 2'd2, 32'h30, 32'h55);
      n = 0;
      while (ack[2] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_wr_ack", 32'(ack[2]), 32'd1);
      @(negedge clk);
      scramble(2);
      chk("rst_wr_wait1", 32'(resp[2]), 32'd0);
      @(negedge clk);
      chk("rst_wr_wait2", 32'(resp[2]), 32'd0);
      rstn[2] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_hold_resp", 32'(resp[2]), 32'd0);
         chk("rst_hold_ack", 32'(ack[2]), 32'd0);
      end
      rstn[2] = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("rst_after_resp", 32'(resp[2]), 32'd0);
      end
      txn(2, 1'b0, 2'd2, 32'h30, 32'h0, "rst_rd");
      chk("rst_rd_value", model[2][12], 32'h55);

      // Address wrap in a 16-word RAM
      txn(2, 1'b1, 2'd2, 32'h40, 32'h77, "wrap_wr");
      txn(2, 1'b0, 2'd2, 32'h00, 32'h0, "wrap_rd");

      // Randomized traffic against the reference model
      for (int k = 0; k < 3; k++) begin
         int words;
         words = (k == 2) ? 16 : 64;
         for (int i = 0; i < words; i++) begin
            txn(k, 1'b1, 2'd2, ($urandom & 32'hFFFF_F000) | 32'(i * 4), $urandom, "rnd_init");
         end
         for (int i = 0; i < 120; i++) begin
            logic [31:0] ra;
            ra = (k == 2) ? $urandom : (($urandom & 32'hFFFF_F000) | ($urandom % 256));
            txn(k, 1'(($urandom)), 2'($urandom), ra, $urandom, "rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
